dmem_controller: RTL and testbench

Main-memory controller downstream of the L2 cache subsystem: it takes the single word-wide request stream that L2 issues on a miss or writeback and serves it from a word-addressed backing array with a fixed access latency. Writes are posted into a small FIFO write buffer and drained in the background. Reads forward from the newest matching buffered write, otherwise they access the array. It is driven through the `address_to_dmem` / `data_from_dmem` side of the bus controller.

---
 rtl/dmem_controller.sv | 176 +++++++++++++++++
 tb/tb_dmem_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_controller.sv
// dmem_controller
// Word-addressed main-memory backing store behind the L2 cache. Requests
// arrive one word at a time. Writes are posted into a small FIFO write
// buffer and committed to the array in the background. Reads take their
// data from the newest buffered write to the same word when one exists;
// otherwise they wait a fixed LATENCY for the array.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   req_in          : request valid (accepted when req_in && !busy_out)
//   we_in           : 1 = write, 0 = read
//   address_in      : byte address (word index = address_in >> 2)
//   data_in         : write data
//   busy_out        : request cannot be accepted this cycle
//   data_out        : read data, qualified by valid_out
//   valid_out       : one-cycle pulse per completed read
//   err_out         : one-cycle pulse per rejected (misaligned/out-of-range) request
//   wb_count_out    : number of occupied write-buffer entries
module dmem_controller #(
    parameter int MEM_DEPTH = 1024,
    parameter int LATENCY   = 4,
    parameter int WB_DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_in,
    input  logic                          we_in,
    input  logic [31:0]                   address_in,
    input  logic [31:0]                   data_in,
    output logic                          busy_out,
    output logic [31:0]                   data_out,
    output logic                          valid_out,
    output logic                          err_out,
    output logic [$clog2(WB_DEPTH+1)-1:0] wb_count_out
);

    localparam int DATA_W = 32;
    localparam int AW     = $clog2(MEM_DEPTH);
    localparam int CW     = $clog2(WB_DEPTH + 1);
    localparam int LW     = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

    state_t              state, state_nxt;
    logic [LW-1:0]       cnt;
    logic [DATA_W-1:0]   mem     [MEM_DEPTH];
    logic [AW-1:0]       wb_addr [WB_DEPTH];
    logic [DATA_W-1:0]   wb_data [WB_DEPTH];
    logic [CW-1:0]       wb_count;
    logic [AW-1:0]       rd_addr;

    logic                accept, req_err, wr_acc, rd_acc;
    logic                fwd_hit, start_miss, start_drain;
    logic                read_done, drain_done, wb_full;
    logic [DATA_W-1:0]   fwd_data;
    logic [AW-1:0]       req_idx;

    assign req_idx      = address_in[AW+1:2];
    assign req_err      = (address_in[1:0] != 2'b00) || (address_in[31:2] >= 30'(MEM_DEPTH));
    assign wb_full      = (wb_count == CW'(WB_DEPTH));
    assign wb_count_out = wb_count;

    // Entry 0 is the oldest write; scanning upward lets the newest match win.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (i < int'(wb_count) && wb_addr[i] == req_idx) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data[i];
            end
        end
    end

    // State register and access counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (start_miss)
                cnt <= LW'(LATENCY - 1);
            else if (start_drain)
                cnt <= LW'(LATENCY);
            else if (cnt != '0)
                cnt <= cnt - LW'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // With LATENCY == 1 a read miss completes without a READ state.
                if (start_miss && LATENCY > 1)
                    state_nxt = READ;
                else if (start_drain)
                    state_nxt = DRAIN;
            end
            READ:    if (cnt == LW'(1)) state_nxt = IDLE;
            DRAIN:   if (cnt == LW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control strobes
    always_comb begin
        busy_out    = (state != IDLE) || wb_full;
        accept      = req_in && !busy_out;
        wr_acc      = accept && we_in && !req_err;
        rd_acc      = accept && !we_in && !req_err;
        start_miss  = rd_acc && !fwd_hit;
        // Any accepted request (even a rejected one) defers the drain a cycle.
        start_drain = (state == IDLE) && !accept && (wb_count != '0);
        read_done   = ((state == READ) && (cnt == LW'(1))) || (start_miss && LATENCY == 1);
        drain_done  = (state == DRAIN) && (cnt == LW'(1));
    end

    // Response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            err_out   <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= read_done || (rd_acc && fwd_hit);
            err_out   <= accept && req_err;
            if (rd_acc && fwd_hit)
                data_out <= fwd_data;
            else if (read_done)
                data_out <= (state == READ) ? mem[rd_addr] : mem[req_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rd_acc)
            rd_addr <= req_idx;
    end

    // Write buffer occupancy
    always_ff @(posedge clk) begin
        if (reset)
            wb_count <= '0;
        else if (drain_done)
            wb_count <= wb_count - CW'(1);
        else if (wr_acc)
            wb_count <= wb_count + CW'(1);
    end

    // Write buffer storage: pop shifts toward entry 0, push lands at the tail.
    // A push never coincides with a pop because DRAIN holds busy_out high.
    always_ff @(posedge clk) begin
        if (drain_done) begin
            for (int i = 0; i < WB_DEPTH - 1; i++) begin
                wb_addr[i] <= wb_addr[i+1];
                wb_data[i] <= wb_data[i+1];
            end
        end else if (wr_acc) begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                if (i == int'(wb_count)) begin
                    wb_addr[i] <= req_idx;
                    wb_data[i] <= data_in;
                end
            end
        end
    end

    // Array commit at the end of the drain; a reset in that cycle discards it.
    always_ff @(posedge clk) begin
        if (drain_done && !reset)
            mem[wb_addr[0]] <= wb_data[0];
    end

endmodule

// File: tb/tb_dmem_controller.sv
module tb_dmem_controller;

    localparam int MEM_DEPTH = 1024;
    localparam int LATENCY   = 4;
    localparam int WB_DEPTH  = 2;
    localparam int CW        = $clog2(WB_DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          req_in;
    logic          we_in;
    logic [31:0]   address_in;
    logic [31:0]   data_in;
    logic          busy_out;
    logic [31:0]   data_out;
    logic          valid_out;
    logic          err_out;
    logic [CW-1:0] wb_count_out;

    always #5 clk = ~clk;

    dmem_controller #(
        .MEM_DEPTH(MEM_DEPTH),
        .LATENCY  (LATENCY),
        .WB_DEPTH (WB_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_in      (req_in),
        .we_in       (we_in),
        .address_in  (address_in),
        .data_in     (data_in),
        .busy_out    (busy_out),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .err_out     (err_out),
        .wb_count_out(wb_count_out)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          err_exp  = 0;
    int          err_seen = 0;
    int          valid_seen = 0;
    logic [31:0] exp_q [$];
    logic [31:0] ref_mem [int];
    logic [31:0] mon_e;

    typedef struct {
        bit          we;
        bit          drain;
        logic [31:0] addr;
        logic [31:0] data;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(MEM_DEPTH));
    endfunction

    // Scoreboard: every read completion pops the oldest expected value.
    always @(negedge clk) begin
        if (err_out === 1'b1) err_seen++;
        if (valid_out === 1'b1) begin
            valid_seen++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: got data 0x%08h, want no response", data_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("read_data", data_out, mon_e);
            end
        end
    end

    // Present one request, hold it until accepted, return in cycle 1.
    task automatic send(input bit we, input logic [31:0] addr, input logic [31:0] data,
                        input bit exp_err, input bit push, input logic [31:0] exp_rd);
        int n;
        n = 0;
        @(negedge clk);
        req_in = 1'b1; we_in = we; address_in = addr; data_in = data;
        while (busy_out && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: busy_out stuck at addr 0x%08h, want accept", addr);
        end
        if (exp_err) err_exp++;
        if (push) exp_q.push_back(exp_rd);
        @(posedge clk);
        #1;
        req_in = 1'b0; we_in = 1'b0;
    endtask

    task automatic mwrite(input logic [31:0] addr, input logic [31:0] data);
        if (!is_err(addr)) ref_mem[int'(addr >> 2)] = data;
        send(1'b1, addr, data, is_err(addr), 1'b0, 32'h0);
    endtask

    task automatic mread(input logic [31:0] addr);
        logic [31:0] e;
        e = ref_mem.exists(int'(addr >> 2)) ? ref_mem[int'(addr >> 2)] : 32'h0;
        send(1'b0, addr, 32'h0, is_err(addr), !is_err(addr), e);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (wb_count_out != '0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: wb_count_out=%0d, want 0", wb_count_out);
        end
    endtask

    // Called in cycle 1 after a read-miss acceptance.
    task automatic check_miss(input string tag, input logic [31:0] exp);
        for (int k = 1; k <= LATENCY; k++) begin
            @(negedge clk);
            chk($sformatf("%s_busy_c%0d", tag, k), 32'(busy_out), 32'(k < LATENCY));
            chk($sformatf("%s_valid_c%0d", tag, k), 32'(valid_out), 32'(k == LATENCY));
            if (k == LATENCY) chk($sformatf("%s_data", tag), data_out, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int v0;
        reset = 1'b1; req_in = 1'b0; we_in = 1'b0; address_in = '0; data_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy",  32'(busy_out),  32'h0);
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_err",   32'(err_out),   32'h0);
        chk("rst_data",  data_out,       32'h0);
        chk("rst_wbcnt", 32'(wb_count_out), 32'h0);

        // Write, let it commit, then read from the array.
        mwrite(32'h10, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_wbcnt_c1", 32'(wb_count_out), 32'h1);
        wait_drain();
        mread(32'h10);
        check_miss("t1", 32'hDEADBEEF);

        // Forwarding from the newest of two buffered writes.
        mwrite(32'h20, 32'h11111111);
        mwrite(32'h20, 32'h22222222);
        mread(32'h20);
        @(negedge clk);
        chk("t2_fwd_valid", 32'(valid_out), 32'h1);
        chk("t2_fwd_data",  data_out, 32'h22222222);
        wait_drain();
        mread(32'h20);
        check_miss("t2", 32'h22222222);

        // Full buffer: third write stalls until the head drain pops.
        wait_drain();
        mwrite(32'h0, 32'h00000A01);
        mwrite(32'h4, 32'h00000A02);
        @(negedge clk);
        req_in = 1'b1; we_in = 1'b1; address_in = 32'h8; data_in = 32'h00000A03;
        chk("t3_busy_full", 32'(busy_out), 32'h1);
        chk("t3_wbcnt_full", 32'(wb_count_out), 32'h2);
        n = 0;
        while (busy_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t3_stall_cycles", 32'(n), 32'(LATENCY + 1));
        chk("t3_wbcnt_pop", 32'(wb_count_out), 32'h1);
        ref_mem[2] = 32'h00000A03;
        @(posedge clk);
        #1 req_in = 1'b0; we_in = 1'b0;
        @(negedge clk);
        chk("t3_wbcnt_refill", 32'(wb_count_out), 32'h2);
        mread(32'h0);
        mread(32'h4);
        mread(32'h8);

        // Errors: misaligned read, out-of-range write.
        wait_drain();
        repeat (LATENCY + 1) @(negedge clk);
        mread(32'h13);
        @(negedge clk);
        chk("t4_err_c1",   32'(err_out),   32'h1);
        chk("t4_valid_c1", 32'(valid_out), 32'h0);
        @(negedge clk);
        chk("t4_err_c2",   32'(err_out),   32'h0);
        mwrite(32'(MEM_DEPTH * 4), 32'h0BADF00D);
        @(negedge clk);
        chk("t4_werr_c1",  32'(err_out),   32'h1);
        chk("t4_wbcnt",    32'(wb_count_out), 32'h0);

        // Table-driven mix of writes, reads, errors and drains.
        vt[0]  = '{1'b1, 1'b0, 32'h100,      32'hA0000001, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 1'b0, 32'h104,      32'hA0000002, 1'b0, 32'h0};
        vt[2]  = '{1'b0, 1'b0, 32'h100,      32'h0,        1'b0, 32'hA0000001};
        vt[3]  = '{1'b0, 1'b0, 32'h104,      32'h0,        1'b0, 32'hA0000002};
        vt[4]  = '{1'b1, 1'b0, 32'h100,      32'hB0000001, 1'b0, 32'h0};
        vt[5]  = '{1'b0, 1'b0, 32'h100,      32'h0,        1'b0, 32'hB0000001};
        vt[6]  = '{1'b0, 1'b0, 32'h102,      32'h0,        1'b1, 32'h0};
        vt[7]  = '{1'b1, 1'b0, 32'h1000,     32'hEEEEEEEE, 1'b1, 32'h0};
        vt[8]  = '{1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 32'h0};
        vt[9]  = '{1'b0, 1'b0, 32'h100,      32'h0,        1'b0, 32'hB0000001};
        vt[10] = '{1'b0, 1'b0, 32'h104,      32'h0,        1'b0, 32'hA0000002};
        vt[11] = '{1'b1, 1'b0, 32'hFFC,      32'hC0FFEE00, 1'b0, 32'h0};
        vt[12] = '{1'b0, 1'b0, 32'hFFC,      32'h0,        1'b0, 32'hC0FFEE00};
        vt[13] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0};
        for (int i = 0; i < 14; i++) begin
            if (vt[i].drain) begin
                wait_drain();
            end else begin
                if (vt[i].we && !vt[i].exp_err) ref_mem[int'(vt[i].addr >> 2)] = vt[i].data;
                send(vt[i].we, vt[i].addr, vt[i].data, vt[i].exp_err,
                     !vt[i].we && !vt[i].exp_err, vt[i].exp_rd);
            end
        end

        // Reset during a read miss with a buffered write pending.
        wait_drain();
        mwrite(32'h40, 32'h55555555);
        mwrite(32'h44, 32'h66666666);
        wait_drain();
        repeat (LATENCY + 2) @(negedge clk);
        send(1'b1, 32'h40, 32'hBBBBBBBB, 1'b0, 1'b0, 32'h0);
        send(1'b0, 32'h44, 32'h0,        1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        v0 = valid_seen;
        @(negedge clk);
        chk("t5_busy",  32'(busy_out),  32'h0);
        chk("t5_valid", 32'(valid_out), 32'h0);
        chk("t5_err",   32'(err_out),   32'h0);
        chk("t5_data",  data_out,       32'h0);
        chk("t5_wbcnt", 32'(wb_count_out), 32'h0);
        repeat (LATENCY + 4) @(negedge clk);
        chk("t5_no_valid", 32'(valid_seen - v0), 32'h0);
        mread(32'h40);
        check_miss("t5", 32'h55555555);

        wait_drain();
        repeat (LATENCY + 4) @(negedge clk);
        chk("err_count",   32'(err_seen),     32'(err_exp));
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
